// File: rtl/enc_dec_apb_master.sv
// Command-to-APB bridge: one outstanding transfer, aligned-address check,
// wait-state timeout, and a single-cycle completion pulse.
module enc_dec_apb_master #(
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       rsp_err,
  output logic [AMBA_ADDR_WIDTH-1:0] paddr,
  output logic [AMBA_WORD-1:0]       pwdata,
  output logic                       pwrite,
  output logic                       psel,
  output logic                       penable,
  input  logic [AMBA_WORD-1:0]       prdata,
  input  logic                       pready,
  input  logic                       pslverr
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

  state_t                     state, state_d;
  logic [CNT_W-1:0]           wait_cnt, wait_cnt_d;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_d;
  logic [AMBA_WORD-1:0]       pwdata_d, rsp_rdata_d;
  logic                       pwrite_d, psel_d, penable_d, rsp_valid_d, rsp_err_d;
  logic                       timeout;

  assign cmd_ready = (state == IDLE);
  assign timeout   = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state;
    wait_cnt_d  = wait_cnt;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    pwrite_d    = pwrite;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_addr[1:0] == 2'b00) begin
            state_d    = SETUP;
            paddr_d    = cmd_addr;
            pwdata_d   = cmd_wdata;
            pwrite_d   = cmd_write;
            wait_cnt_d = '0;
          end else begin
            // Misaligned: report the error without touching the bus.
            state_d     = ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready is checked first so it wins over an expiring counter.
        if (pready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = (pwrite || pslverr) ? '0 : prdata;
        end else if (timeout) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      wait_cnt  <= wait_cnt_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      pwrite    <= pwrite_d;
      psel      <= psel_d;
      penable   <= penable_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end
endmodule

// File: tb/tb_enc_dec_apb_master.sv
// Directed bench for enc_dec_apb_master: expected responses are queued at
// issue time and checked by an independent monitor on rsp_valid.
module tb_enc_dec_apb_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, pslverr;

  enc_dec_apb_master #(
    .AMBA_ADDR_WIDTH(32), .AMBA_WORD(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rsp_count = 0;
  int   rsp_cyc = 0;
  int   psel_cnt = 0;
  int   pen_cnt = 0;
  int   t_acc = 0;

  // Slave model: holds pready low for wait_n ACCESS cycles.
  int          wait_n = 0;
  int          acc_cnt = 0;
  logic        slverr_en = 1'b0;
  logic [31:0] rd_val = 32'h0;
  assign pready  = psel & penable & (acc_cnt >= wait_n);
  assign pslverr = slverr_en & pready;
  assign prdata  = rd_val;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on every completion, plus per-cycle bus checks.
  always @(negedge clk) begin
    psel_cnt += int'(psel);
    pen_cnt  += int'(penable);
    chk("penable_without_psel", {31'd0, penable & ~psel}, 32'd0);
    if (rsp_valid === 1'b1) begin
      exp_t e;
      rsp_count++;
      rsp_cyc = cyc;
      chk("psel_low_at_rsp", {31'd0, psel}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic push_exp(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (cmd_ready !== 1'b1) chk("cmd_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    psel_cnt  = 0;
    pen_cnt   = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    wait_ready();
    @(posedge clk);
    #1;
    t_acc     = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int guard = 0;
    while (rsp_count < target && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (rsp_count < target) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t0, t1, guard;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_psel", {31'd0, psel}, 32'd0);
    chk("reset_penable", {31'd0, penable}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_pwrite", {31'd0, pwrite}, 32'd0);
    chk("reset_paddr", paddr, 32'd0);
    chk("reset_pwdata", pwdata, 32'd0);

    // Zero-wait write
    wait_n = 0;
    push_exp(32'h0, 1'b0);
    issue(1'b1, 32'h4, 32'hA5A5_0001);
    wait_rsp(1);
    chk("wr_latency", rsp_cyc - t_acc, 32'd2);
    chk("wr_psel_cycles", psel_cnt, 32'd2);
    chk("wr_penable_cycles", pen_cnt, 32'd1);
    chk("wr_paddr", paddr, 32'h4);
    chk("wr_pwdata", pwdata, 32'hA5A5_0001);
    chk("wr_pwrite_hold", {31'd0, pwrite}, 32'd1);

    // Read with three wait states
    wait_n = 3; rd_val = 32'h0000_0010;
    push_exp(32'h10, 1'b0);
    issue(1'b0, 32'h8, 32'h0);
    wait_rsp(2);
    chk("rd_wait_latency", rsp_cyc - t_acc, 32'd5);
    chk("rd_wait_penable_cycles", pen_cnt, 32'd4);
    chk("rd_wait_pwrite", {31'd0, pwrite}, 32'd0);

    // Read that never gets pready
    wait_n = 1000; rd_val = 32'hDEAD_BEEF;
    push_exp(32'h0, 1'b1);
    issue(1'b0, 32'hC, 32'h0);
    wait_rsp(3);
    chk("to_latency", rsp_cyc - t_acc, 32'd17);
    chk("to_penable_cycles", pen_cnt, 32'd16);
    @(negedge clk);
    chk("to_psel_dropped", {31'd0, psel}, 32'd0);

    // Pready arrives in the last allowed cycle
    wait_n = 15; rd_val = 32'h1234_5678;
    push_exp(32'h1234_5678, 1'b0);
    issue(1'b0, 32'h14, 32'h0);
    wait_rsp(4);
    chk("edge_penable_cycles", pen_cnt, 32'd16);

    // Misaligned address
    wait_n = 0;
    push_exp(32'h0, 1'b1);
    issue(1'b1, 32'h6, 32'h5555_5555);
    wait_rsp(5);
    chk("mis_latency", rsp_cyc - t_acc, 32'd0);
    chk("mis_psel_cycles", psel_cnt, 32'd0);
    chk("mis_paddr_held", paddr, 32'h14);

    // Slave error
    slverr_en = 1'b1; rd_val = 32'hFFFF_0000;
    push_exp(32'h0, 1'b1);
    issue(1'b0, 32'h10, 32'h0);
    wait_rsp(6);
    slverr_en = 1'b0;

    // Reset during ACCESS
    wait_n = 1000;
    issue(1'b0, 32'h20, 32'h0);
    guard = 0;
    while (!(psel && penable) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_reached_access", {31'd0, psel & penable}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_psel", {31'd0, psel}, 32'd0);
    chk("rst_penable", {31'd0, penable}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (20) @(negedge clk);
    chk("rst_no_rsp", rsp_count, 32'd6);

    // Back-to-back writes with cmd_valid held
    wait_n = 0;
    push_exp(32'h0, 1'b0);
    push_exp(32'h0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h1111_1111;
    wait_ready();
    @(posedge clk);
    #1;
    t0 = cyc;
    cmd_addr = 32'hC; cmd_wdata = 32'h2222_2222;
    @(negedge clk);
    wait_ready();
    @(posedge clk);
    #1;
    t1 = cyc;
    cmd_valid = 1'b0;
    chk("b2b_accept_gap", t1 - t0, 32'd3);
    chk("b2b_first_rsp_count", rsp_count, 32'd7);
    wait_rsp(8);
    chk("b2b_paddr", paddr, 32'hC);
    chk("b2b_pwdata", pwdata, 32'h2222_2222);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1, "watchdog");
  end
endmodule
